mem_stream_reader: RTL

Read-side DMA engine that sits directly upstream of the `Memory` block, in its non-showahead configuration. It accepts a command of the form (start address, word count), and it issues one read per cycle on Memory's read port. It collects the data Memory returns one cycle later and presents it on a valid/ready output stream with a last-word flag. A small internal FIFO absorbs downstream backpressure, because Memory's read pipeline cannot be stalled.

---
 rtl/mem_stream_pkg.sv | 17 +
 rtl/mem_stream_reader_fifo.sv | 46 ++++
 rtl/mem_stream_reader.sv | 118 +++++++++++
 3 files changed

// File: rtl/mem_stream_pkg.sv
// Shared types for the memory stream reader: FSM states and the FIFO entry layout.
package mem_stream_pkg;

  localparam int DEF_WIDTH_BYTES = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } reader_state_t;

  typedef struct packed {
    logic                           last;
    logic [DEF_WIDTH_BYTES*8-1:0]   data;
  } stream_entry_t;

endpackage

// File: rtl/mem_stream_reader_fifo.sv
// Small synchronous FIFO of stream entries; synchronous active-low reset flushes it.
module stream_fifo
  import mem_stream_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = stream_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  entry_t        push_entry,
  input  logic          pop,
  output entry_t        head,
  output logic [CW-1:0] count,
  output logic          empty
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  // Head reads as zero when empty so the stream outputs are clean after reset.
  assign head   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_pop)      count <= count + CW'(1);
      else if (!push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/mem_stream_reader.sv
// Read-side DMA: turns (addr, len) commands into one Memory read per cycle and
// streams the returned words out through a credit-protected FIFO.
module mem_stream_reader
  import mem_stream_pkg::*;
#(
  parameter int  MEM_WIDTH_BYTES = 64,
  parameter int  MEM_DEPTH       = 65536,
  parameter int  MAX_LEN         = 256,
  parameter int  FIFO_DEPTH      = 4,
  localparam int AW              = $clog2(MEM_DEPTH),
  localparam int LW              = $clog2(MAX_LEN + 1),
  localparam int DW              = MEM_WIDTH_BYTES * 8,
  localparam int CW              = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid_in,
  output logic          cmd_ready_out,
  input  logic [AW-1:0] cmd_addr_in,
  input  logic [LW-1:0] cmd_len_in,
  output logic [AW-1:0] mem_read_addr_out,
  output logic          mem_read_out,
  input  logic [DW-1:0] mem_read_data_in,
  output logic          out_valid_out,
  input  logic          out_ready_in,
  output logic [DW-1:0] out_data_out,
  output logic          out_last_out,
  output logic          busy_out,
  input  logic          debugen_in
);

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } entry_t;

  reader_state_t state, state_nxt;
  logic [AW-1:0] cur_addr;
  logic [LW-1:0] remaining;
  logic          inflight, last_d;
  logic          cmd_fire, cmd_start, issue, pop, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit;
  entry_t        head, push_entry;

  // Tracing is a simulation concern; the hook is accepted and left unconnected here.
  logic debugen_unused;
  assign debugen_unused = debugen_in;

  assign cmd_ready_out = (state == IDLE) && reset;
  assign cmd_fire      = cmd_valid_in && cmd_ready_out;
  assign cmd_start     = cmd_fire && (cmd_len_in != '0);

  // Words already owed to the FIFO: stored ones plus the read returning next cycle.
  assign credit = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign issue  = (state == RUN) && (credit < (CW+1)'(FIFO_DEPTH));

  assign mem_read_out      = issue;
  assign mem_read_addr_out = cur_addr;
  assign busy_out          = (state != IDLE);

  assign out_valid_out = !fifo_empty;
  assign out_data_out  = head.data;
  assign out_last_out  = head.last;
  assign pop           = out_valid_out && out_ready_in;

  assign push_entry.last = last_d;
  assign push_entry.data = mem_read_data_in;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_start) state_nxt = RUN;
      RUN:     if (issue && remaining == LW'(1)) state_nxt = DRAIN;
      DRAIN:   if (!inflight && fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_addr  <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      last_d    <= 1'b0;
    end else begin
      inflight <= issue;
      last_d   <= issue && (remaining == LW'(1));
      if (cmd_start) begin
        cur_addr  <= cmd_addr_in;
        remaining <= cmd_len_in;
      end else if (issue) begin
        cur_addr  <= (cur_addr == AW'(MEM_DEPTH - 1)) ? '0 : cur_addr + 1'b1;
        remaining <= remaining - LW'(1);
      end
    end
  end

  stream_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (inflight),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count),
    .empty      (fifo_empty)
  );

endmodule
